data_ram_resp: RTL and testbench
================================

DATA_RAM_RESP -- requirements
Module: data_ram_resp

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of the number of 32-bit storage words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning extra busy cycles per access (0..15).
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n_i, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port req_i, input, 1, access request from the memory stage.
REQ-006 SHALL have port we_i, input, 1, write request (1) or read request (0).
REQ-007 SHALL have port addr_i, input, 32, byte address; bits [1:0] ignored; word index = addr_i[DEPTH_LOG2+1:2].
REQ-008 SHALL have port wdata_i, input, 32, write data, already lane-aligned by the initiator.
REQ-009 SHALL have port be_i, input, 4, byte-lane write enables; be_i[n] covers bits [8n+7:8n].
REQ-010 SHALL have port ready_o, output, 1, block can accept a request this cycle.
REQ-011 SHALL have port rvalid_o, output, 1, one-cycle completion pulse for both reads and writes.
REQ-012 SHALL have port rdata_o, output, 32, read data, valid while rvalid_o=1.
REQ-013 SHALL have port err_o, output, 1, out-of-range access flag, valid while rvalid_o=1.
REQ-014 SHALL have port parity_err_o, output, 1, parity mismatch on read, valid while rvalid_o=1 (see Configuration).

Function
REQ-015 SHALL implement states IDLE, BUSY, RESP; ready_o=1 only in IDLE.
REQ-016 SHALL accept a request when req_i=1 and ready_o=1, registering we_i, addr_i, wdata_i, be_i in that cycle.
REQ-017 On acceptance SHALL go to BUSY with wait counter loaded with WAIT_CYCLES; if WAIT_CYCLES=0 SHALL go directly to RESP.
REQ-018 In BUSY SHALL decrement the counter each cycle and move to RESP on the cycle the counter reaches 0.
REQ-019 SHALL perform the storage access (read sample or write commit) on the edge entering RESP, never earlier.
REQ-020 SHALL assert rvalid_o for exactly one cycle in RESP, then return to IDLE; latency from acceptance edge to rvalid_o = WAIT_CYCLES+1 cycles.
REQ-021 Writes SHALL update only lanes with be_i[n]=1; other lanes keep prior contents; be_i=0 is a legal no-op write still acknowledged.
REQ-022 Write completion SHALL drive rdata_o=0.
REQ-023 Reads SHALL return the full stored word regardless of be_i.
REQ-024 Address with any of addr_i[31:DEPTH_LOG2+2] nonzero SHALL be out-of-range: no write, rdata_o=0, err_o=1 with rvalid_o.
REQ-025 req_i while not ready SHALL be ignored (not queued); the initiator holds req_i until accepted.
REQ-026 A read following a write to the same word SHALL return the written data (back-to-back, no hazard).
REQ-027 Outside RESP, rvalid_o, err_o, parity_err_o SHALL be 0; rdata_o holds its last value.

Reset
REQ-028 While rst_n_i=0: state IDLE, counter 0, ready_o=1, rvalid_o=0, rdata_o=0, err_o=0, parity_err_o=0.
REQ-029 Reset mid-access SHALL abandon the access with no write commit and no rvalid_o pulse.
REQ-030 Storage contents SHALL NOT be reset.

Configuration
REQ-031 Macro DATA_RAM_PARITY_EN defined: each word stores one even-parity bit per byte, written with its lane; read sets parity_err_o=1 if any byte's parity mismatches.
REQ-032 Macro DATA_RAM_PARITY_EN undefined: no parity storage; parity_err_o tied to 0.

Verification
REQ-033 WAIT_CYCLES=2: write 0xDEADBEEF to 0x0000_0010 be=4'b1111, then read 0x10 -> each rvalid_o exactly 3 cycles after acceptance, rdata_o=0xDEADBEEF.
REQ-034 Word 0x10=0xDEADBEEF; write wdata 0x0000_AA00 be=4'b0010 -> read returns 0xDEADAAEF.
REQ-035 Read 0x0001_0000 (DEPTH_LOG2=10) -> rvalid_o with err_o=1, rdata_o=0; write there leaves word 0 unchanged.
REQ-036 Hold req_i=1 continuously with alternating addresses -> ready_o low during BUSY/RESP, one acceptance per 4 cycles, no lost or duplicated access.
REQ-037 Assert rst_n_i=0 during BUSY of a write 0x12345678 to 0x20 -> outputs take reset values immediately, no rvalid_o, subsequent read of 0x20 returns prior contents.
REQ-038 With DATA_RAM_PARITY_EN, force one stored parity bit inverted -> read gives parity_err_o=1; without macro parity_err_o stays 0.

Source files
------------

// File: rtl/data_ram_resp.sv
// Word RAM behind a memory-stage request port; latency WAIT_CYCLES+1 cycles, ready only in IDLE (no queuing).
// DATA_RAM_PARITY_EN adds per-byte even parity, checked on reads and reported on parity_err_o.
module data_ram_resp #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        ready_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        parity_err_o
);

    localparam int         DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
    localparam bit         DIRECT  = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    accept, enter_resp;

    logic                    we_q, oor_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [31:0]             wdata_q;
    logic [3:0]              be_q;

    logic                    req_oor;
    logic [DEPTH_LOG2-1:0]   req_idx;
    logic                    unused_addr_lsb;

    logic                    acc_we, acc_oor;
    logic [DEPTH_LOG2-1:0]   acc_idx;
    logic [31:0]             acc_wdata;
    logic [3:0]              acc_be;

    logic [31:0]             rdata_q;
    logic                    err_q;
    logic [31:0]             mem [DEPTH];

    assign req_oor         = |(addr_i >> (DEPTH_LOG2 + 2));
    assign req_idx         = addr_i[DEPTH_LOG2+1:2];
    assign unused_addr_lsb = ^addr_i[1:0];

    // With no wait cycles the access happens on the acceptance edge itself,
    // so it must use the live request rather than the captured copy.
    assign acc_we    = DIRECT ? we_i    : we_q;
    assign acc_oor   = DIRECT ? req_oor : oor_q;
    assign acc_idx   = DIRECT ? req_idx : idx_q;
    assign acc_wdata = DIRECT ? wdata_i : wdata_q;
    assign acc_be    = DIRECT ? be_i    : be_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    accept = 1'b1;
                    if (DIRECT) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = WAIT_LD;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef DATA_RAM_PARITY_EN
    logic [3:0] par_mem [DEPTH];
    logic       perr_q;

    function automatic logic [3:0] lane_par(input logic [31:0] w);
        logic [3:0] p;
        for (int n = 0; n < 4; n++) p[n] = ^w[8*n +: 8];
        return p;
    endfunction
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            oor_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
`ifdef DATA_RAM_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= we_i;
                oor_q   <= req_oor;
                idx_q   <= req_idx;
                wdata_q <= wdata_i;
                be_q    <= be_i;
            end
            if (enter_resp) begin
                err_q   <= acc_oor;
                rdata_q <= (acc_we || acc_oor) ? 32'd0 : mem[acc_idx];
`ifdef DATA_RAM_PARITY_EN
                perr_q  <= !acc_we && !acc_oor &&
                           (par_mem[acc_idx] != lane_par(mem[acc_idx]));
`endif
            end
        end
    end

    // Storage is deliberately not reset; an abandoned access never reaches
    // enter_resp because reset forces the FSM back to IDLE.
    always_ff @(posedge clk_i) begin
        if (enter_resp && acc_we && !acc_oor) begin
            for (int n = 0; n < 4; n++) begin
                if (acc_be[n]) begin
                    mem[acc_idx][8*n +: 8] <= acc_wdata[8*n +: 8];
`ifdef DATA_RAM_PARITY_EN
                    par_mem[acc_idx][n]    <= ^acc_wdata[8*n +: 8];
`endif
                end
            end
        end
    end

    assign ready_o  = (state_q == IDLE);
    assign rvalid_o = (state_q == RESP);
    assign rdata_o  = rdata_q;
    assign err_o    = rvalid_o && err_q;
`ifdef DATA_RAM_PARITY_EN
    assign parity_err_o = rvalid_o && perr_q;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_data_ram_resp.sv
// Directed bench for data_ram_resp (DEPTH_LOG2=10, WAIT_CYCLES=2); outputs sampled on falling edges.
module tb_data_ram_resp;

    logic        clk = 1'b0;
    logic        rst_n, req, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        ready, rvalid, err, parity_err;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_ram_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .req_i        (req),
        .we_i         (we),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .be_i         (be),
        .ready_o      (ready),
        .rvalid_o     (rvalid),
        .rdata_o      (rdata),
        .err_o        (err),
        .parity_err_o (parity_err)
    );

    // One complete access; returns at the falling edge where rvalid is high.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, output logic [31:0] rd, output logic er,
                          output logic pe, output int lat);
        int guard;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        guard = 0;
        while (!ready && guard < 10) begin @(negedge clk); guard++; end
        @(negedge clk);
        req = 1'b0;
        lat = 1;
        while (!rvalid && lat < 20) begin @(negedge clk); lat++; end
        checks++;
        if (!rvalid) begin
            errors++;
            $display("FAIL access_timeout: addr %h no rvalid within %0d cycles", a, lat);
        end
        rd = rdata; er = err; pe = parity_err;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0; be = 4'd0;
        #12;
        checks++; if (ready !== 1'b1)       begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
        checks++; if (rvalid !== 1'b0)      begin errors++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
        checks++; if (rdata !== 32'd0)      begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        checks++; if (err !== 1'b0)         begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (parity_err !== 1'b0)  begin errors++; $display("FAIL reset_perr: got %b want 0", parity_err); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read;
        logic [31:0] rd; logic er, pe; int lat;
        access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, pe, lat);
        checks++; if (lat !== 3)            begin errors++; $display("FAIL wr_latency: got %0d want 3", lat); end
        checks++; if (rd !== 32'd0)         begin errors++; $display("FAIL wr_rdata: got %h want 0", rd); end
        checks++; if (er !== 1'b0)          begin errors++; $display("FAIL wr_err: got %b want 0", er); end
        @(negedge clk);
        checks++; if (rvalid !== 1'b0)      begin errors++; $display("FAIL wr_pulse_width: rvalid %b want 0", rvalid); end
        checks++; if (ready !== 1'b1)       begin errors++; $display("FAIL wr_back_idle: ready %b want 1", ready); end
        access(1'b0, 32'h10, 32'h0, 4'hF, rd, er, pe, lat);
        checks++; if (lat !== 3)            begin errors++; $display("FAIL rd_latency: got %0d want 3", lat); end
        checks++; if (rd !== 32'hDEADBEEF)  begin errors++; $display("FAIL rd_data: got %h want deadbeef", rd); end
        checks++; if (er !== 1'b0)          begin errors++; $display("FAIL rd_err: got %b want 0", er); end
        checks++; if (pe !== 1'b0)          begin errors++; $display("FAIL rd_perr: got %b want 0", pe); end
    endtask

    task automatic test_byte_enable;
        logic [31:0] rd; logic er, pe; int lat;
        access(1'b1, 32'h10, 32'h0000AA00, 4'b0010, rd, er, pe, lat);
        access(1'b0, 32'h10, 32'h0, 4'hF, rd, er, pe, lat);
        checks++; if (rd !== 32'hDEADAAEF)  begin errors++; $display("FAIL be_lane1: got %h want deadaaef", rd); end
        access(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, rd, er, pe, lat);
        checks++; if (lat !== 3)            begin errors++; $display("FAIL be_zero_ack: latency %0d want 3", lat); end
        access(1'b0, 32'h10, 32'h0, 4'b0000, rd, er, pe, lat);
        checks++; if (rd !== 32'hDEADAAEF)  begin errors++; $display("FAIL be_zero_noop: got %h want deadaaef", rd); end
        access(1'b1, 32'h13, 32'h5A000000, 4'b1000, rd, er, pe, lat);
        access(1'b0, 32'h12, 32'h0, 4'b0001, rd, er, pe, lat);
        checks++; if (rd !== 32'h5AADAAEF)  begin errors++; $display("FAIL be_lane3: got %h want 5aadaaef", rd); end
    endtask

    task automatic test_out_of_range;
        logic [31:0] rd; logic er, pe; int lat;
        access(1'b1, 32'h0, 32'h11223344, 4'hF, rd, er, pe, lat);
        access(1'b0, 32'h0001_0000, 32'h0, 4'hF, rd, er, pe, lat);
        checks++; if (er !== 1'b1)          begin errors++; $display("FAIL oor_rd_err: got %b want 1", er); end
        checks++; if (rd !== 32'd0)         begin errors++; $display("FAIL oor_rd_data: got %h want 0", rd); end
        access(1'b1, 32'h0001_0000, 32'hFFFFFFFF, 4'hF, rd, er, pe, lat);
        checks++; if (er !== 1'b1)          begin errors++; $display("FAIL oor_wr_err: got %b want 1", er); end
        access(1'b0, 32'h8000_0000, 32'h0, 4'hF, rd, er, pe, lat);
        checks++; if (er !== 1'b1)          begin errors++; $display("FAIL oor_msb_err: got %b want 1", er); end
        access(1'b0, 32'h0, 32'h0, 4'hF, rd, er, pe, lat);
        checks++; if (rd !== 32'h11223344)  begin errors++; $display("FAIL oor_word0: got %h want 11223344", rd); end
        checks++; if (er !== 1'b0)          begin errors++; $display("FAIL oor_word0_err: got %b want 0", er); end
        repeat (3) @(negedge clk);
        checks++; if (rdata !== 32'h11223344) begin errors++; $display("FAIL rdata_hold: got %h want 11223344", rdata); end
        checks++; if (rvalid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL idle_flags: rvalid %b err %b want 0 0", rvalid, err); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a_tab [4];
        logic [31:0] d_tab [4];
        logic [31:0] rd; logic er, pe;
        int acc_n [4];
        int k, n, nval, nacc, overlap, lat;
        bit adv;
        a_tab = '{32'h40, 32'h44, 32'h40, 32'h44};
        d_tab = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
        k = 0; n = 0; nval = 0; nacc = 0; overlap = 0; adv = 1'b0;
        @(negedge clk);
        req = 1'b1; we = 1'b1; be = 4'hF; addr = a_tab[0]; wdata = d_tab[0];
        while (nval < 4 && n < 80) begin
            if (adv) begin
                k++; adv = 1'b0;
                if (k < 4) begin addr = a_tab[k]; wdata = d_tab[k]; end
                else req = 1'b0;
            end
            if (rvalid) nval++;
            if (rvalid && ready) overlap++;
            if (req && ready && nacc < 4) begin acc_n[nacc] = n; nacc++; adv = 1'b1; end
            @(negedge clk);
            n++;
        end
        req = 1'b0;
        checks++; if (nacc !== 4)    begin errors++; $display("FAIL b2b_accepts: got %0d want 4", nacc); end
        checks++; if (nval !== 4)    begin errors++; $display("FAIL b2b_rvalids: got %0d want 4", nval); end
        checks++; if (overlap !== 0) begin errors++; $display("FAIL b2b_ready_in_resp: got %0d want 0", overlap); end
        for (int i = 1; i < nacc; i++) begin
            checks++;
            if (acc_n[i] - acc_n[i-1] !== 4) begin
                errors++; $display("FAIL b2b_spacing%0d: got %0d want 4", i, acc_n[i] - acc_n[i-1]);
            end
        end
        access(1'b0, 32'h40, 32'h0, 4'hF, rd, er, pe, lat);
        checks++; if (rd !== 32'hC2C2C2C2) begin errors++; $display("FAIL b2b_rd40: got %h want c2c2c2c2", rd); end
        access(1'b0, 32'h44, 32'h0, 4'hF, rd, er, pe, lat);
        checks++; if (rd !== 32'hD3D3D3D3) begin errors++; $display("FAIL b2b_rd44: got %h want d3d3d3d3", rd); end
    endtask

    task automatic test_reset_mid_access;
        logic [31:0] rd; logic er, pe; int lat, seen;
        access(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, rd, er, pe, lat);
        access(1'b0, 32'h20, 32'h0, 4'hF, rd, er, pe, lat);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h12345678; be = 4'hF;
        @(negedge clk);
        req = 1'b0;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL mid_busy_ready: got %b want 0", ready); end
        rst_n = 1'b0;
        #1;
        checks++; if (ready !== 1'b1)  begin errors++; $display("FAIL mid_rst_ready: got %b want 1", ready); end
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL mid_rst_rdata: got %h want 0", rdata); end
        checks++; if (rvalid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL mid_rst_flags: rvalid %b err %b want 0 0", rvalid, err); end
        seen = 0;
        for (int i = 0; i < 4; i++) begin @(negedge clk); if (rvalid) seen++; end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin @(negedge clk); if (rvalid) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL mid_rst_no_rvalid: got %0d pulses want 0", seen); end
        access(1'b0, 32'h20, 32'h0, 4'hF, rd, er, pe, lat);
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL mid_rst_no_commit: got %h want cafef00d", rd); end
    endtask

    task automatic test_parity;
        logic [31:0] rd; logic er, pe; int lat;
`ifdef DATA_RAM_PARITY_EN
        access(1'b0, 32'h20, 32'h0, 4'hF, rd, er, pe, lat);
        checks++; if (pe !== 1'b0) begin errors++; $display("FAIL par_clean: got %b want 0", pe); end
        dut.par_mem[8] = dut.par_mem[8] ^ 4'b0100;
        access(1'b0, 32'h20, 32'h0, 4'hF, rd, er, pe, lat);
        checks++; if (pe !== 1'b1) begin errors++; $display("FAIL par_flip: got %b want 1", pe); end
`else
        access(1'b0, 32'h20, 32'h0, 4'hF, rd, er, pe, lat);
        checks++; if (pe !== 1'b0) begin errors++; $display("FAIL par_disabled: got %b want 0", pe); end
`endif
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_byte_enable;
        test_out_of_range;
        test_back_to_back;
        test_reset_mid_access;
        test_parity;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
